// File: rtl/coin_pkg.sv
// Shared types and constants for the coin dispenser: FSM state encoding,
// chute indices and the coin value table.
package coin_pkg;

  // Dispense sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_FIRE      = 3'd2,
    ST_WAIT_DROP = 3'd3,
    ST_GAP       = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  // Chute indices; also the bit position in solenoid/coin_sense
  localparam logic [1:0] PENNY   = 2'd0;
  localparam logic [1:0] NICKEL  = 2'd1;
  localparam logic [1:0] DIME    = 2'd2;
  localparam logic [1:0] QUARTER = 2'd3;

  // Value in cents of each chute, indexed by chute index
  localparam logic [4:0] COIN_VALUE [4] = '{5'd1, 5'd5, 5'd10, 5'd25};

  // Cents for one coin of the given chute
  function automatic logic [4:0] coin_value(input logic [1:0] idx);
    return COIN_VALUE[idx];
  endfunction

  // One-hot solenoid drive pattern for the given chute
  function automatic logic [3:0] coin_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/coin_dispenser_if.sv
// CPU-facing MMIO bundle of the coin dispenser.
//
// Handshake: req_valid is a single-cycle pulse carrying req_amount; it is
// accepted only when the block is in IDLE (busy, done and error all low),
// otherwise it is dropped. ack is a single-cycle pulse that clears the sticky
// done/error flags and returns the block to IDLE; it has no effect while a
// request is still running. Status outputs are registered and may be polled
// at any time.
interface coin_dispenser_if #(
  parameter int AMOUNT_W = 10
);
  logic                req_valid;
  logic [AMOUNT_W-1:0] req_amount;
  logic                ack;
  logic                busy;
  logic                done;
  logic                error;
  logic [AMOUNT_W-1:0] remaining;
  logic [1:0]          last_coin;

  // CPU side
  modport master (
    output req_valid, req_amount, ack,
    input  busy, done, error, remaining, last_coin
  );

  // Dispenser side
  modport slave (
    input  req_valid, req_amount, ack,
    output busy, done, error, remaining, last_coin
  );
endinterface

// File: rtl/coin_dispenser_sense_sync.sv
// Beam-break sensor front end: 2-flop synchronizer on each raw chute level
// followed by a registered rising-edge detector. A raw edge shows up as a
// one-cycle rise pulse after the third clock edge.
module sense_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sense,
  output logic [3:0] rise
);

  logic [3:0] sync_1;
  logic [3:0] sync_2;
  logic [3:0] sync_2_d;

  // Synchronize raw levels and register the rising edge of the synced level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1   <= '0;
      sync_2   <= '0;
      sync_2_d <= '0;
      rise     <= '0;
    end else begin
      sync_1   <= sense;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
      rise     <= sync_2 & ~sync_2_d;
    end
  end

endmodule

// File: rtl/coin_dispenser.sv
// Coin dispenser: takes a change amount from the CPU, splits it greedily into
// quarters/dimes/nickels/pennies and, per coin, pulses the chute solenoid and
// waits for the chute's beam-break confirmation before moving on.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int AMOUNT_W       = 10,
  parameter int PULSE_CYCLES   = 1500000,
  parameter int GAP_CYCLES     = 300000,
  parameter int TIMEOUT_CYCLES = 30000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] coin_sense,
  output logic [3:0] solenoid,
  output state_t     fsm_state,
  coin_dispenser_if.slave bus
);

  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam int TOUT_W  = $clog2(TIMEOUT_CYCLES + 1);

  // Counter limits: *_MAX is the saturation value, *_LAST the value held
  // during the final cycle of the interval.
  localparam logic [PULSE_W-1:0] PULSE_MAX  = PULSE_W'(PULSE_CYCLES);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TOUT_W-1:0]  TOUT_MAX   = TOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TOUT_W-1:0]  TOUT_LAST  = TOUT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [AMOUNT_W-1:0] remaining;
  logic [1:0]          last_coin;
  logic                busy;
  logic                done;
  logic                error;
  logic                drop_seen;
  logic [PULSE_W-1:0]  pulse_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [TOUT_W-1:0]   tout_cnt;

  logic [3:0]          detect;
  logic                drop_hit;
  logic [1:0]          pick_coin;
  logic [AMOUNT_W-1:0] fired_value;
  logic [PULSE_W-1:0]  pulse_inc;
  logic [GAP_W-1:0]    gap_inc;
  logic [TOUT_W-1:0]   tout_inc;
  logic                pulse_end;
  logic                gap_end;
  logic                tout_end;

  sense_sync u_sense_sync (
    .clock (clock),
    .reset (reset),
    .sense (coin_sense),
    .rise  (detect)
  );

  // Only the chute that was just fired can confirm a drop
  assign drop_hit    = detect[last_coin];
  assign fired_value = AMOUNT_W'(coin_value(last_coin));

  // Saturating increments and interval-end flags for the three timers
  assign pulse_inc = (pulse_cnt == PULSE_MAX) ? pulse_cnt : pulse_cnt + PULSE_W'(1);
  assign gap_inc   = (gap_cnt   == GAP_MAX)   ? gap_cnt   : gap_cnt + GAP_W'(1);
  assign tout_inc  = (tout_cnt  == TOUT_MAX)  ? tout_cnt  : tout_cnt + TOUT_W'(1);
  assign pulse_end = (pulse_cnt >= PULSE_LAST);
  assign gap_end   = (gap_cnt >= GAP_LAST);
  assign tout_end  = (tout_cnt >= TOUT_LAST);

  // Greedy choice: largest coin that still fits in the remaining amount
  always_comb begin
    pick_coin = PENNY;
    if (remaining >= AMOUNT_W'(coin_value(QUARTER))) begin
      pick_coin = QUARTER;
    end else if (remaining >= AMOUNT_W'(coin_value(DIME))) begin
      pick_coin = DIME;
    end else if (remaining >= AMOUNT_W'(coin_value(NICKEL))) begin
      pick_coin = NICKEL;
    end
  end

  // Dispense sequencer with registered status and solenoid outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      solenoid  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      remaining <= '0;
      last_coin <= PENNY;
      drop_seen <= 1'b0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
      tout_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_amount != '0) begin
              remaining <= bus.req_amount;
              busy      <= 1'b1;
              state     <= ST_SELECT;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_SELECT: begin
          if (remaining == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            last_coin <= pick_coin;
            solenoid  <= coin_onehot(pick_coin);
            drop_seen <= 1'b0;
            pulse_cnt <= '0;
            tout_cnt  <= '0;
            state     <= ST_FIRE;
          end
        end

        ST_FIRE: begin
          // An early drop is remembered, but the pulse always runs full length
          tout_cnt <= tout_inc;
          if (drop_hit) begin
            drop_seen <= 1'b1;
          end
          if (pulse_end) begin
            solenoid <= '0;
            if (drop_seen || drop_hit) begin
              remaining <= remaining - fired_value;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end else begin
              state <= ST_WAIT_DROP;
            end
          end else begin
            pulse_cnt <= pulse_inc;
          end
        end

        ST_WAIT_DROP: begin
          tout_cnt <= tout_inc;
          if (drop_hit) begin
            remaining <= remaining - fired_value;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end else if (tout_end) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ST_ERROR;
          end
        end

        ST_GAP: begin
          // Sensor bounce during the settle time is deliberately ignored
          if (gap_end) begin
            state <= ST_SELECT;
          end else begin
            gap_cnt <= gap_inc;
          end
        end

        ST_DONE: begin
          if (bus.ack) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_ERROR: begin
          // remaining/last_coin are kept so the CPU can see what failed
          solenoid <= '0;
          if (bus.ack) begin
            error <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          solenoid <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.error     = error;
  assign bus.remaining = remaining;
  assign bus.last_coin = last_coin;
  assign fsm_state     = state;

endmodule

// File: doc/coin_dispenser.md
Name: coin_dispenser

Overview:
Output-side counterpart to the beam-break coin intake: the CPU requests a change amount in cents over MMIO, and the block dispenses it. It splits the amount greedily into quarters, dimes, nickels and pennies. For each coin it pulses that chute's solenoid, then confirms the drop on the chute's beam-break sensor. Busy/done/error status and the remaining amount are exposed for CPU polling via lw.

Parameters:
AMOUNT_W, 10, width of amount/remaining (max 1023 cents)
PULSE_CYCLES, 1500000, solenoid on-time (50 ms at 30 MHz)
GAP_CYCLES, 300000, settle time between coins (10 ms)
TIMEOUT_CYCLES, 30000000, max cycles from FIRE entry to drop detection (1 s)

Ports:
clock  in  1  system clock (30 MHz PLL output)
reset  in  1  asynchronous, active-low reset
req_valid  in  1  one-cycle pulse from MMIO sw; start dispense
req_amount  in  AMOUNT_W  cents requested, sampled with req_valid
ack  in  1  one-cycle pulse; clears done/error, returns to IDLE
coin_sense  in  4  raw beam-broken levels, asynchronous: bit0 penny, bit1 nickel, bit2 dime, bit3 quarter
solenoid  out  4  chute drive, same bit order, active high
busy  out  1  request in progress
done  out  1  sticky: amount fully dispensed
error  out  1  sticky: drop timeout
remaining  out  AMOUNT_W  cents still owed
last_coin  out  2  index of coin last fired (0=1c, 1=5c, 2=10c, 3=25c)

Behaviour:
- Reset (async assert, sync deassert) clears: state=IDLE, solenoid=0, busy=0, done=0, error=0, remaining=0, last_coin=0, all timers and sync flops. Asserting reset mid-FIRE drops solenoid immediately, without waiting for a clock edge.
- coin_sense passes through a 2-flop synchronizer, then a registered rising-edge detector. A pin edge becomes a detect pulse on the 3rd clock edge after it arrives.
- IDLE:
  - req_valid && req_amount>0: latch remaining=req_amount, busy=1, go to SELECT.
  - req_valid && req_amount==0: done=1 on the next cycle, go to DONE, no solenoid activity.
- SELECT (1 cycle):
  - remaining==0: go to DONE, busy=0, done=1.
  - Otherwise pick the largest coin value <= remaining in the order 25, 10, 5, 1. Set last_coin, go to FIRE.
- FIRE:
  - solenoid[last_coin]=1 for exactly PULSE_CYCLES cycles; only one solenoid bit is ever high.
  - A timeout timer starts at FIRE entry.
  - A detect on chute last_coin during FIRE is registered as a drop, but the pulse still runs to full length.
  - When the pulse ends: drop already seen -> go to GAP; otherwise -> go to WAIT_DROP.
- WAIT_DROP:
  - Detect on chute last_coin: go to GAP.
  - Timer reaches TIMEOUT_CYCLES: go to ERROR.
- On each confirmed drop, remaining -= value(last_coin), applied once at the FIRE/WAIT_DROP -> GAP transition. The result is always >= 0 by construction.
- GAP: wait GAP_CYCLES, then go to SELECT. Sense edges in GAP are ignored (bounce, double counts).
- Detects on chutes other than last_coin are ignored in every state.
- DONE: done=1, busy=0. req_valid is ignored. ack -> IDLE, done=0.
- ERROR:
  - error=1, busy=0, solenoid=0.
  - remaining and last_coin hold their values for CPU readout.
  - ack -> IDLE, error=0, remaining unchanged until the next request.
- req_valid outside IDLE is ignored.
- ack and req_valid in the same cycle while in DONE or ERROR: ack is taken, req_valid is dropped.
- ack in IDLE/SELECT/FIRE/WAIT_DROP/GAP: no effect.
- Timers are sized to ceil(log2(max parameter + 1)) bits. Counters saturate and never wrap.

Decomposition:
- Shared package coin_pkg:
  - state encoding (IDLE, SELECT, FIRE, WAIT_DROP, GAP, DONE, ERROR)
  - coin index constants PENNY=0, NICKEL=1, DIME=2, QUARTER=3
  - COIN_VALUE table {1, 5, 10, 25}
- One sub-module, sense_sync: a 4-bit 2-flop synchronizer plus rising-edge detector, with the same asynchronous active-low reset.

Test Plan:
(bench parameters: PULSE_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20; sensor model raises sense 2 cycles after the solenoid rises)
- req_amount=41 -> solenoid fires bits 3, 2, 1, 0 in order, each high exactly 4 cycles. remaining steps 41 -> 16 -> 6 -> 1 -> 0. Then done=1, busy=0, error=0.
- req_amount=0 -> done=1 one cycle later, busy never 1, solenoid stays 0. ack -> done=0, back in IDLE.
- req_amount=30, sensor model disabled for the quarter chute -> solenoid[3] high 4 cycles, then error=1 exactly 20 cycles after FIRE entry. remaining=30, last_coin=3, solenoid=0.
- req_amount=5, sensor model pulses only the dime chute plus a double edge on the nickel chute during GAP -> dime edge ignored, error after timeout. Separate run with correct sense: a single decrement to 0, the GAP edge is not double counted.
- reset driven low during FIRE of a 25c coin -> solenoid=0 before the next clock edge, all outputs at reset values. After release, a req_amount=25 dispenses normally.
- In DONE, ack and req_valid (req_amount=10) in the same cycle -> returns to IDLE with no dispense started. A later lone req_valid (req_amount=10) dispenses one dime.
